cpu_control_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/cpu_decode.sv | 54 +++++
 rtl/cpu_control_unit.sv | 165 ++++++++++++++++
 tb/tb_cpu_control_unit.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
//======================================================================
// Module      : cpu_pkg
// Description : Shared opcode/state encodings and ALU/Skipcond constants
// Revision    : 1.0
//======================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [3:0] {
        OP_LOAD     = 4'h1,
        OP_STORE    = 4'h2,
        OP_ADD      = 4'h3,
        OP_SUBT     = 4'h4,
        OP_AND      = 4'h5,
        OP_OR       = 4'h6,
        OP_HALT     = 4'h7,
        OP_SKIPCOND = 4'h8,
        OP_JUMP     = 4'h9,
        OP_CLEAR    = 4'hA
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_REQ  = 3'd1,
        ST_F_LAT  = 3'd2,
        ST_DECODE = 3'd3,
        ST_M_REQ  = 3'd4,
        ST_M_LAT  = 3'd5,
        ST_EXEC   = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_add = 3'b001;
    localparam logic [2:0] c_alu_sub = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b100;

    localparam logic [1:0] c_skip_neg   = 2'b00;
    localparam logic [1:0] c_skip_zero  = 2'b01;
    localparam logic [1:0] c_skip_pos   = 2'b10;
    localparam logic [1:0] c_skip_never = 2'b11;

endpackage

`default_nettype wire

// File: rtl/cpu_decode.sv
//======================================================================
// Module      : cpu_decode
// Description : Opcode to instruction class, ALU select and illegal flag
// Revision    : 1.0
//======================================================================
`default_nettype none

module cpu_decode
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       mem_read,
    output logic       store,
    output logic       single_cycle,
    output logic       halt,
    output logic       illegal,
    output logic [2:0] alu_sel
);

    always_comb begin
        mem_read     = 1'b0;
        store        = 1'b0;
        single_cycle = 1'b0;
        halt         = 1'b0;
        illegal      = 1'b0;
        alu_sel      = c_alu_add;
        case (opcode)
            OP_LOAD:  mem_read = 1'b1;
            OP_STORE: store    = 1'b1;
            OP_ADD: begin
                mem_read = 1'b1;
                alu_sel  = c_alu_add;
            end
            OP_SUBT: begin
                mem_read = 1'b1;
                alu_sel  = c_alu_sub;
            end
            OP_AND: begin
                mem_read = 1'b1;
                alu_sel  = c_alu_and;
            end
            OP_OR: begin
                mem_read = 1'b1;
                alu_sel  = c_alu_or;
            end
            OP_HALT:                      halt         = 1'b1;
            OP_SKIPCOND, OP_JUMP, OP_CLEAR: single_cycle = 1'b1;
            default:                      illegal      = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/cpu_control_unit.sv
//======================================================================
// Module      : cpu_control_unit
// Description : Multi-cycle fetch/decode/execute controller, accumulator CPU
// Revision    : 1.0
//======================================================================
`default_nettype none

module cpu_control_unit
    import cpu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_sel,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  halted,
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ac
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d, mbr_q, mbr_d, ac_q, ac_d;
    logic                  illegal_q, illegal_d;

    logic [3:0] w_opcode;
    logic       w_mem_read, w_store, w_single, w_halt, w_illegal, w_skip;

    assign w_opcode = ir_q[DATA_WIDTH-1 -: 4];

    cpu_decode u_decode (
        .opcode       (w_opcode),
        .mem_read     (w_mem_read),
        .store        (w_store),
        .single_cycle (w_single),
        .halt         (w_halt),
        .illegal      (w_illegal),
        .alu_sel      (alu_sel)
    );

    // AC is treated as two's complement for the Skipcond comparisons.
    always_comb begin
        w_skip = 1'b0;
        case (ir_q[ADDR_WIDTH-1 -: 2])
            c_skip_neg:  w_skip = ac_q[DATA_WIDTH-1];
            c_skip_zero: w_skip = (ac_q == '0);
            c_skip_pos:  w_skip = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
            default:     w_skip = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        mar_d     = mar_q;
        mbr_d     = mbr_q;
        ac_d      = ac_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE:  if (run) state_d = ST_F_REQ;
            ST_F_REQ: state_d = ST_F_LAT;
            ST_F_LAT: begin
                ir_d    = mem_rdata;
                pc_d    = pc_q + ADDR_WIDTH'(1);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                mar_d = ir_q[ADDR_WIDTH-1:0];
                if (w_illegal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (w_halt) begin
                    state_d = ST_HALT;
                end else if (w_single) begin
                    state_d = ST_F_REQ;
                    if (w_opcode == OP_JUMP)
                        pc_d = ir_q[ADDR_WIDTH-1:0];
                    else if (w_opcode == OP_CLEAR)
                        ac_d = '0;
                    else if (w_skip)
                        pc_d = pc_q + ADDR_WIDTH'(1);
                end else if (w_mem_read || w_store) begin
                    state_d = ST_M_REQ;
                end
            end
            ST_M_REQ: state_d = w_store ? ST_F_REQ : ST_M_LAT;
            ST_M_LAT: begin
                mbr_d   = mem_rdata;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                ac_d    = (w_opcode == OP_LOAD) ? mbr_q : alu_out;
                state_d = ST_F_REQ;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            mar_q     <= '0;
            mbr_q     <= '0;
            ac_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            mar_q     <= mar_d;
            mbr_q     <= mbr_d;
            ac_q      <= ac_d;
            illegal_q <= illegal_d;
        end
    end

    // Memory strobes depend only on the state register, so reset kills a write at once.
    always_comb begin
        mem_cs   = 1'b0;
        mem_oe   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = mar_q;
        case (state_q)
            ST_F_REQ: begin
                mem_cs   = 1'b1;
                mem_oe   = 1'b1;
                mem_addr = pc_q;
            end
            ST_M_REQ: begin
                mem_cs = 1'b1;
                mem_we = w_store;
                mem_oe = !w_store;
            end
            default: ;
        endcase
    end

    assign mem_wdata = ac_q;
    assign alu_a     = ac_q;
    assign alu_b     = mbr_q;
    assign halted    = (state_q == ST_HALT);
    assign illegal   = illegal_q;
    assign pc        = pc_q;
    assign ac        = ac_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
//======================================================================
// Module      : tb_cpu_control_unit
// Description : Self-checking bench: RAM/ALU models plus ISA reference model
// Revision    : 1.0
//======================================================================
`default_nettype none

module tb_cpu_control_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        mem_cs, mem_we, mem_oe;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;
    logic        halted, illegal;
    logic [11:0] pc;
    logic [15:0] ac;

    logic [15:0] mem     [0:4095];
    logic [15:0] ref_mem [0:4095];
    logic        ld_en = 1'b0;
    logic [11:0] ld_addr;
    logic [15:0] ld_data;

    logic [27:0] exp_wr_q [$];
    logic [11:0] exp_pc;
    logic [15:0] exp_ac;
    logic        exp_ill;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mul_prog [0:10] = '{16'h110C, 16'h210E, 16'h110D, 16'h310B,
                                     16'h210D, 16'h110E, 16'h310F, 16'h210E,
                                     16'h8400, 16'h9102, 16'h7000};

    always #5 clk = ~clk;

    cpu_control_unit #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (12),
        .RESET_PC   (12'h100)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_oe    (mem_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .halted    (halted),
        .illegal   (illegal),
        .pc        (pc),
        .ac        (ac)
    );

    always_comb begin
        alu_out = '0;
        case (alu_sel)
            3'b000:  alu_out = alu_a & alu_b;
            3'b001:  alu_out = alu_a + alu_b;
            3'b010:  alu_out = alu_a - alu_b;
            3'b100:  alu_out = alu_a | alu_b;
            default: alu_out = '0;
        endcase
    end

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (mem_cs && mem_we)
            mem[mem_addr] <= mem_wdata;
        if (mem_cs && mem_oe)
            mem_rdata <= mem[mem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Each observed write is matched in order against the reference model's stores.
    always @(negedge clk) begin
        if (rst_n && mem_cs && mem_we) begin
            if (exp_wr_q.size() == 0) begin
                check_eq("wr_unexpected", {31'd0, mem_we}, 32'd0);
            end else begin
                logic [27:0] e;
                e = exp_wr_q.pop_front();
                check_eq("wr_addr", {20'd0, mem_addr}, {20'd0, e[27:16]});
                check_eq("wr_data", {16'd0, mem_wdata}, {16'd0, e[15:0]});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic poke(input logic [11:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        ld_en = 1'b0;
    endtask

    task automatic model_run();
        logic [11:0] p, x;
        logic [15:0] a, ir;
        bit          done;
        p = 12'h100;
        a = '0;
        done = 1'b0;
        exp_ill = 1'b0;
        for (int s = 0; s < 5000 && !done; s++) begin
            ir = ref_mem[p];
            p  = p + 12'd1;
            x  = ir[11:0];
            case (ir[15:12])
                4'h1: a = ref_mem[x];
                4'h2: begin
                    ref_mem[x] = a;
                    exp_wr_q.push_back({x, a});
                end
                4'h3: a = a + ref_mem[x];
                4'h4: a = a - ref_mem[x];
                4'h5: a = a & ref_mem[x];
                4'h6: a = a | ref_mem[x];
                4'h7: done = 1'b1;
                4'h8: begin
                    case (ir[11:10])
                        2'b00:   if ($signed(a) < 0) p = p + 12'd1;
                        2'b01:   if (a == 16'd0) p = p + 12'd1;
                        2'b10:   if ($signed(a) > 0) p = p + 12'd1;
                        default: ;
                    endcase
                end
                4'h9: p = x;
                4'hA: a = '0;
                default: begin
                    done = 1'b1;
                    exp_ill = 1'b1;
                end
            endcase
        end
        exp_pc = p;
        exp_ac = a;
    endtask

    task automatic enter_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        exp_wr_q.delete();
        step(1);
    endtask

    task automatic leave_reset(input bit use_model);
        if (use_model) model_run();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic start_prog(input string name);
        @(negedge clk);
        run = 1'b1;
        @(posedge clk);
        #1;
        check_eq({name, "_freq_cs"}, {31'd0, mem_cs}, 32'd1);
        check_eq({name, "_freq_oe"}, {31'd0, mem_oe}, 32'd1);
        check_eq({name, "_freq_addr"}, {20'd0, mem_addr}, 32'h100);
        run = 1'b0;
    endtask

    task automatic finish_prog(input string name);
        for (int i = 0; i < 3000 && !halted; i++) step(1);
        check_eq({name, "_halted"}, {31'd0, halted}, 32'd1);
        check_eq({name, "_pc"}, {20'd0, pc}, {20'd0, exp_pc});
        check_eq({name, "_ac"}, {16'd0, ac}, {16'd0, exp_ac});
        check_eq({name, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        check_eq({name, "_wr_left"}, exp_wr_q.size(), 32'd0);
        repeat (3) begin
            step(1);
            check_eq({name, "_quiet"}, {31'd0, mem_cs}, 32'd0);
        end
    endtask

    task automatic skip_case(input string name, input logic [15:0] acv,
                             input logic [15:0] sk, input logic [11:0] pc_exp);
        enter_reset();
        poke(12'h100, 16'h110C);
        poke(12'h101, sk);
        poke(12'h102, 16'h7000);
        poke(12'h103, 16'h7000);
        poke(12'h10C, acv);
        leave_reset(1'b1);
        start_prog(name);
        step(8);
        check_eq({name, "_pc_pre"}, {20'd0, pc}, 32'h102);
        step(1);
        check_eq({name, "_pc_post"}, {20'd0, pc}, {20'd0, pc_exp});
        finish_prog(name);
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        step(3);
        check_eq("rst_pc", {20'd0, pc}, 32'h100);
        check_eq("rst_ac", {16'd0, ac}, 32'd0);
        check_eq("rst_cs", {31'd0, mem_cs}, 32'd0);
        check_eq("rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_oe", {31'd0, mem_oe}, 32'd0);
        check_eq("rst_halted", {31'd0, halted}, 32'd0);
        check_eq("rst_illegal", {31'd0, illegal}, 32'd0);
        check_eq("rst_alu_sel", {29'd0, alu_sel}, 32'd1);

        // Load: AC lands exactly 6 cycles after the fetch request.
        enter_reset();
        poke(12'h100, 16'h110C);
        poke(12'h101, 16'h7000);
        poke(12'h10C, 16'h0007);
        leave_reset(1'b1);
        start_prog("ld");
        step(5);
        check_eq("ld_ac_pre", {16'd0, ac}, 32'd0);
        step(1);
        check_eq("ld_ac", {16'd0, ac}, 32'd7);
        check_eq("ld_pc", {20'd0, pc}, 32'h101);
        finish_prog("ld");

        // Store: write commits 4 cycles after its fetch, next fetch follows.
        enter_reset();
        poke(12'h100, 16'h110C);
        poke(12'h101, 16'h210E);
        poke(12'h102, 16'h7000);
        poke(12'h10C, 16'h0007);
        poke(12'h10E, 16'h0000);
        leave_reset(1'b1);
        start_prog("st");
        step(9);
        check_eq("st_we", {31'd0, mem_we}, 32'd1);
        check_eq("st_addr", {20'd0, mem_addr}, 32'h10E);
        check_eq("st_mem_pre", {16'd0, mem[12'h10E]}, 32'd0);
        step(1);
        check_eq("st_mem_post", {16'd0, mem[12'h10E]}, 32'd7);
        check_eq("st_next_fetch", {20'd0, mem_addr}, 32'h102);
        check_eq("st_next_oe", {31'd0, mem_oe}, 32'd1);
        step(2);
        check_eq("st_halt_pre", {31'd0, halted}, 32'd0);
        step(1);
        check_eq("st_halt_at3", {31'd0, halted}, 32'd1);
        finish_prog("st");

        skip_case("skz", 16'h0000, 16'h8400, 12'h103);
        skip_case("skn", 16'hFFFF, 16'h8000, 12'h103);
        skip_case("skp", 16'h8000, 16'h8800, 12'h102);
        skip_case("skx", 16'h0000, 16'h8C00, 12'h102);

        // Jump to the top of memory; the fetch increment wraps PC to 0.
        enter_reset();
        poke(12'h100, 16'h9FFF);
        poke(12'hFFF, 16'hA000);
        poke(12'h000, 16'h7000);
        leave_reset(1'b1);
        start_prog("wrap");
        step(3);
        check_eq("wrap_jump_pc", {20'd0, pc}, 32'hFFF);
        check_eq("wrap_fetch_addr", {20'd0, mem_addr}, 32'hFFF);
        step(2);
        check_eq("wrap_pc0", {20'd0, pc}, 32'h000);
        finish_prog("wrap");

        enter_reset();
        for (int i = 0; i < 11; i++) poke(12'h100 + 12'(i), mul_prog[i]);
        poke(12'h10B, 16'h0005);
        poke(12'h10C, 16'h0007);
        poke(12'h10D, 16'h0000);
        poke(12'h10E, 16'h0000);
        poke(12'h10F, 16'hFFFF);
        leave_reset(1'b1);
        start_prog("mul");
        finish_prog("mul");
        check_eq("mul_m10d", {16'd0, mem[12'h10D]}, 32'h0023);
        check_eq("mul_pc", {20'd0, pc}, 32'h10B);

        enter_reset();
        poke(12'h100, 16'hF000);
        leave_reset(1'b1);
        start_prog("ill");
        step(2);
        check_eq("ill_halt_pre", {31'd0, halted}, 32'd0);
        step(1);
        check_eq("ill_halted", {31'd0, halted}, 32'd1);
        check_eq("ill_flag", {31'd0, illegal}, 32'd1);
        check_eq("ill_pc", {20'd0, pc}, 32'h101);
        finish_prog("ill");

        // Reset during a Store's write cycle: strobe drops with no clock edge.
        enter_reset();
        poke(12'h100, 16'h110C);
        poke(12'h101, 16'h210E);
        poke(12'h10C, 16'h0007);
        poke(12'h10E, 16'h1234);
        leave_reset(1'b0);
        start_prog("abort");
        step(9);
        check_eq("abort_we_before", {31'd0, mem_we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_we_async", {31'd0, mem_we}, 32'd0);
        check_eq("abort_cs_async", {31'd0, mem_cs}, 32'd0);
        step(1);
        check_eq("abort_mem", {16'd0, mem[12'h10E]}, 32'h1234);
        check_eq("abort_pc", {20'd0, pc}, 32'h100);
        check_eq("abort_ac", {16'd0, ac}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
